// File: rtl/shreg_deser_pkg.sv
// rtl/shreg_deser_pkg.sv - shared types and defaults for the 16-bit serial deserializer
package shreg_deser_pkg;

  localparam int DESER_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/shreg_deser16_if.sv
// rtl/shreg_deser16_if.sv - serial input / parallel output handshake bundle of shreg_deser16
interface shreg_deser16_if import shreg_deser_pkg::*; #(parameter int W = DESER_W) ();

  logic         clr;
  logic         sdi;
  logic         sdi_vld;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         ovf;
  logic         busy;
  logic         perr;

  modport master (
    output clr, sdi, sdi_vld, dout_rdy,
    input  dout, dout_vld, ovf, busy, perr
  );

  modport slave (
    input  clr, sdi, sdi_vld, dout_rdy,
    output dout, dout_vld, ovf, busy, perr
  );

endinterface

// File: rtl/shreg_deser_hold.sv
// rtl/shreg_deser_hold.sv - one-entry valid/ready holding buffer with sticky overflow flag
module shreg_deser_hold #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         ovf
);

  // A word arriving in the same cycle the held word drains replaces it with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr) begin
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (wr) begin
      if (!dout_vld || rdy) begin
        dout     <= wdata;
        dout_vld <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (dout_vld && rdy) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/shreg_deser16.sv
// rtl/shreg_deser16.sv - MSB-first serial-to-parallel receiver with one-word output buffer
// Optional even-parity frame check enabled by defining DESER_PARITY_EN.
module shreg_deser16 import shreg_deser_pkg::*; #(
  parameter int W     = DESER_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  shreg_deser16_if.slave   bus
);

  state_t       state;
  logic [W-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] shifted;
  logic [W-1:0] word;
  logic         last_bit;
  logic         done;

  assign shifted  = {sreg[W-2:0], bus.sdi};
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(W - 1));

`ifdef DESER_PARITY_EN
  logic perr_q;
  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign done     = bus.sdi_vld && (state == PAR) && !(^{sreg, bus.sdi});
  assign word     = sreg;
  assign bus.perr = perr_q;
`else
  assign done     = bus.sdi_vld && last_bit;
  assign word     = shifted;
  assign bus.perr = 1'b0;
`endif

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
`ifdef DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (bus.clr) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else if (bus.sdi_vld) begin
        case (state)
          IDLE: begin
            sreg  <= shifted;
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
          SHIFT: begin
            sreg <= shifted;
            if (last_bit) begin
              cnt <= '0;
`ifdef DESER_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`ifdef DESER_PARITY_EN
          PAR: begin
            state  <= IDLE;
            perr_q <= ^{sreg, bus.sdi};
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  shreg_deser_hold #(.W(W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.clr),
    .wr       (done),
    .wdata    (word),
    .rdy      (bus.dout_rdy),
    .dout     (bus.dout),
    .dout_vld (bus.dout_vld),
    .ovf      (bus.ovf)
  );

endmodule

// File: tb/tb_shreg_deser16.sv
// tb/tb_shreg_deser16.sv - scoreboard bench for shreg_deser16 (honours DESER_PARITY_EN)
module tb_shreg_deser16;

  localparam int W = 16;
`ifdef DESER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shreg_deser16_if #(.W(W)) bus ();

  shreg_deser16 #(.W(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: bits of the frame in flight, words owed to the consumer, flags.
  int        bits[$];
  int        q[$];
  bit        m_full = 0;
  bit        m_ovf  = 0;
  bit        m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    bits.delete();
    q.delete();
    m_full = 0;
    m_ovf  = 0;
    m_perr = 0;
  endtask

  task automatic model_edge(input bit v, input bit b, input bit r, input bit c);
    bit hs, complete;
    int word;
    if (c) begin
      model_reset();
      return;
    end
    hs       = m_full && r;
    complete = 0;
    word     = 0;
    m_perr   = 0;
    if (v) begin
      bits.push_back(int'(b));
      if (bits.size() == FL) begin
        for (int i = 0; i < W; i++) word = word * 2 + bits[i];
        if (FL == W || (($countones(word) + bits[W]) % 2 == 0)) complete = 1;
        else m_perr = 1;
        bits.delete();
      end
    end
    if (complete) begin
      if (!m_full || hs) begin
        q.push_back(word);
        m_full = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (hs) begin
      m_full = 0;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit r, input bit c);
    bus.sdi_vld  = v;
    bus.sdi      = b;
    bus.dout_rdy = r;
    bus.clr      = c;
    @(posedge clk);
    if (rst_n) model_edge(v, b, r, c);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
  endtask

  task automatic send_parity(input logic [W-1:0] w, input bit p, input bit r);
    send_word(w, r);
    if (FL > W) step(1'b1, p, r, 1'b0);
  endtask

  // Monitor: compares every cycle; pops the owed word on each handshake.
  always @(negedge clk) begin
    chk("dout_vld", bus.dout_vld, m_full);
    chk("ovf", bus.ovf, m_ovf);
    chk("busy", bus.busy, bits.size() != 0);
    chk("perr", bus.perr, m_perr);
    if (bus.dout_vld) begin
      if (q.size() == 0) chk("dout_owed", 32'(bus.dout), 32'hDEAD_BEEF);
      else begin
        chk("dout", 32'(bus.dout), 32'(q[0]));
        if (bus.dout_rdy && !bus.clr) void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.sdi = 0; bus.sdi_vld = 0; bus.dout_rdy = 0; bus.clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_vld", bus.dout_vld, 1'b0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // 1: single word, consumer ready
    send_word(16'hA5C3, 1);
    chk("t1_vld", bus.dout_vld, FL == W);
    step(0, 0, 1, 0);
    if (FL > W) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);

    // 2: overflow while stalled, sticky until clr
    send_parity(16'h1234, 1'b1, 0);
    send_parity(16'hFFFF, 1'b0, 0);
    step(0, 0, 0, 0);
    chk("t2_dout", 32'(bus.dout), 32'h1234);
    chk("t2_ovf", bus.ovf, 1'b1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t2_ovf_sticky", bus.ovf, 1'b1);
    step(0, 0, 0, 1);
    chk("t2_ovf_clr", bus.ovf, 1'b0);

    // 3: back-to-back words, no bubble
    send_parity(16'h0001, 1'b1, 1);
    send_parity(16'h8000, 1'b1, 1);
    repeat (2) step(0, 0, 1, 0);
    chk("t3_ovf", bus.ovf, 1'b0);

    // 4: clr aborts a partial word
    for (int i = 0; i < 7; i++) step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    chk("t4_busy", bus.busy, 1'b0);
    send_parity(16'h00FF, 1'b0, 0);
    step(0, 0, 0, 0);
    chk("t4_dout", 32'(bus.dout), 32'h00FF);
    step(0, 0, 1, 0);

    // 5: async reset mid-word with a held word
    send_parity(16'h5A5A, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 0);
    bus.sdi_vld = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_dout", 32'(bus.dout), 32'h0);
    chk("t5_vld", bus.dout_vld, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_ovf", bus.ovf, 1'b0);
    model_reset();
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

`ifdef DESER_PARITY_EN
    // 6: parity good then bad
    send_parity(16'h0003, 1'b0, 0);
    step(0, 0, 1, 0);
    send_parity(16'h0003, 1'b1, 0);
    chk("t6_perr", bus.perr, 1'b1);
    chk("t6_vld", bus.dout_vld, 1'b0);
    step(0, 0, 0, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    repeat (3) step(0, 0, 1, 0);
    chk("end_owed", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
